// File: rtl/gcm_pkg.sv
// Shared widths and FSM state encoding for the GCM block feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gcm_pkg;

    localparam int GCM_BLK_W = 128;
    localparam int WORD_W    = 32;
    localparam int IV_W      = 96;
    localparam int KEY_W     = 128;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        FILL_AAD  = 3'd2,
        ISSUE_AAD = 3'd3,
        FILL_PT   = 3'd4,
        ISSUE_PT  = 3'd5,
        WAIT_TAG  = 3'd6
    } gcm_state_t;

endpackage

// File: rtl/gcm_word_packer.sv
// Inserts one 32-bit word into a 128-bit block; word 0 lands in the most significant slot.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module gcm_word_packer
    import gcm_pkg::*;
(
    input  logic [GCM_BLK_W-1:0] blk_cur,
    input  logic [1:0]           word_idx,
    input  logic [WORD_W-1:0]    word,
    output logic [GCM_BLK_W-1:0] blk_next
);

    // Overwrite only the slot selected by word_idx; untouched slots keep their value (zero after a clear).
    always_comb begin
        blk_next = blk_cur;
        case (word_idx)
            2'd0:    blk_next[GCM_BLK_W-1            -: WORD_W] = word;
            2'd1:    blk_next[GCM_BLK_W-1-WORD_W     -: WORD_W] = word;
            2'd2:    blk_next[GCM_BLK_W-1-2*WORD_W   -: WORD_W] = word;
            default: blk_next[GCM_BLK_W-1-3*WORD_W   -: WORD_W] = word;
        endcase
    end

endmodule

// File: rtl/gcm_block_feeder.sv
// Packs a 32-bit AAD/plaintext word stream into 128-bit blocks and sequences them into a GCM core.
// Latency: a block is presented one cycle after its last word transfers.
// Backpressure: o_ready drops while a block waits for i_blk_ack and outside the fill states.
module gcm_block_feeder
    import gcm_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [KEY_W-1:0]     i_cipher_key,
    input  logic [IV_W-1:0]      i_iv,
    input  logic [LEN_W-1:0]     i_aad_size,
    input  logic [LEN_W-1:0]     i_plain_text_size,
    input  logic [WORD_W-1:0]    i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_new_instance,
    output logic                 o_pt_instance,
    output logic [KEY_W-1:0]     o_cipher_key,
    output logic [IV_W-1:0]      o_iv,
    output logic [GCM_BLK_W-1:0] o_aad,
    output logic [GCM_BLK_W-1:0] o_plain_text,
    output logic [LEN_W-1:0]     o_aad_size,
    output logic [LEN_W-1:0]     o_plain_text_size,
    input  logic                 i_blk_ack,
    input  logic                 i_tag_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    // Remaining-word counters count 32-bit words, so the five low size bits are dropped.
    localparam int CNT_W = LEN_W - 5;

    gcm_state_t           state;
    logic [GCM_BLK_W-1:0] blk;
    logic [GCM_BLK_W-1:0] blk_next;
    logic [1:0]           word_idx;
    logic [CNT_W-1:0]     aad_rem;
    logic [CNT_W-1:0]     pt_rem;
    logic                 word_xfer;

    assign word_xfer = i_valid && o_ready;

    gcm_word_packer u_packer (
        .blk_cur  (blk),
        .word_idx (word_idx),
        .word     (i_data),
        .blk_next (blk_next)
    );

    // Message sequencer: latches operands, fills and issues blocks, waits for the tag; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            blk               <= '0;
            word_idx          <= '0;
            aad_rem           <= '0;
            pt_rem            <= '0;
            o_ready           <= 1'b0;
            o_new_instance    <= 1'b0;
            o_pt_instance     <= 1'b0;
            o_cipher_key      <= '0;
            o_iv              <= '0;
            o_aad             <= '0;
            o_plain_text      <= '0;
            o_aad_size        <= '0;
            o_plain_text_size <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            o_new_instance <= 1'b0;
            o_pt_instance  <= 1'b0;
            o_done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_cipher_key      <= i_cipher_key;
                        o_iv              <= i_iv;
                        o_aad_size        <= i_aad_size;
                        o_plain_text_size <= i_plain_text_size;
                        aad_rem           <= i_aad_size[LEN_W-1:5];
                        pt_rem            <= i_plain_text_size[LEN_W-1:5];
                        o_new_instance    <= 1'b1;
                        o_busy            <= 1'b1;
                        state             <= INIT;
                    end
                end

                INIT: begin
                    if (aad_rem != '0) begin
                        blk      <= '0;
                        word_idx <= '0;
                        o_ready  <= 1'b1;
                        state    <= FILL_AAD;
                    end else if (pt_rem != '0) begin
                        blk      <= '0;
                        word_idx <= '0;
                        o_ready  <= 1'b1;
                        state    <= FILL_PT;
                    end else begin
                        state    <= WAIT_TAG;
                    end
                end

                FILL_AAD: begin
                    if (word_xfer) begin
                        blk      <= blk_next;
                        word_idx <= word_idx + 2'd1;
                        if (aad_rem != '0) begin
                            aad_rem <= aad_rem - CNT_W'(1);
                        end
                        // Block closes on its fourth word or on the last AAD word.
                        if (word_idx == 2'd3 || aad_rem == CNT_W'(1)) begin
                            o_aad   <= blk_next;
                            o_ready <= 1'b0;
                            state   <= ISSUE_AAD;
                        end
                    end
                end

                ISSUE_AAD: begin
                    if (i_blk_ack) begin
                        if (aad_rem != '0) begin
                            blk      <= '0;
                            word_idx <= '0;
                            o_ready  <= 1'b1;
                            state    <= FILL_AAD;
                        end else if (pt_rem != '0) begin
                            blk      <= '0;
                            word_idx <= '0;
                            o_ready  <= 1'b1;
                            state    <= FILL_PT;
                        end else begin
                            state    <= WAIT_TAG;
                        end
                    end
                end

                FILL_PT: begin
                    if (word_xfer) begin
                        blk      <= blk_next;
                        word_idx <= word_idx + 2'd1;
                        if (pt_rem != '0) begin
                            pt_rem <= pt_rem - CNT_W'(1);
                        end
                        if (word_idx == 2'd3 || pt_rem == CNT_W'(1)) begin
                            o_plain_text  <= blk_next;
                            o_pt_instance <= 1'b1;
                            o_ready       <= 1'b0;
                            state         <= ISSUE_PT;
                        end
                    end
                end

                ISSUE_PT: begin
                    if (i_blk_ack) begin
                        if (pt_rem != '0) begin
                            blk      <= '0;
                            word_idx <= '0;
                            o_ready  <= 1'b1;
                            state    <= FILL_PT;
                        end else begin
                            state    <= WAIT_TAG;
                        end
                    end
                end

                WAIT_TAG: begin
                    if (i_tag_ready) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_block_feeder.sv
// Directed bench for gcm_block_feeder with hand-computed expected blocks and strobe counts.
// Latency: checks blocks one cycle after the last word and o_ready low while blocks wait for ack.
// Backpressure: exercised with continuous and 1/0-toggled i_valid.
module tb_gcm_block_feeder;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [127:0] i_cipher_key;
    logic [95:0]  i_iv;
    logic [63:0]  i_aad_size;
    logic [63:0]  i_plain_text_size;
    logic [31:0]  i_data;
    logic         i_valid;
    logic         o_ready;
    logic         o_new_instance;
    logic         o_pt_instance;
    logic [127:0] o_cipher_key;
    logic [95:0]  o_iv;
    logic [127:0] o_aad;
    logic [127:0] o_plain_text;
    logic [63:0]  o_aad_size;
    logic [63:0]  o_plain_text_size;
    logic         i_blk_ack;
    logic         i_tag_ready;
    logic         o_busy;
    logic         o_done;

    int total = 0;
    int bad   = 0;
    int new_cnt = 0;
    int pt_cnt  = 0;
    int rdy_cnt = 0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY_B = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [95:0]  IV_A  = 96'hCAFEBABE_DEADBEEF_01234567;

    logic [31:0] wq [0:15];

    gcm_block_feeder #(.LEN_W(64)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_cipher_key      (i_cipher_key),
        .i_iv              (i_iv),
        .i_aad_size        (i_aad_size),
        .i_plain_text_size (i_plain_text_size),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .o_new_instance    (o_new_instance),
        .o_pt_instance     (o_pt_instance),
        .o_cipher_key      (o_cipher_key),
        .o_iv              (o_iv),
        .o_aad             (o_aad),
        .o_plain_text      (o_plain_text),
        .o_aad_size        (o_aad_size),
        .o_plain_text_size (o_plain_text_size),
        .i_blk_ack         (i_blk_ack),
        .i_tag_ready       (i_tag_ready),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe and ready counters sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (o_new_instance) new_cnt++;
            if (o_pt_instance)  pt_cnt++;
            if (o_ready)        rdy_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [63:0] aad, input logic [63:0] pt, input logic [127:0] key);
        i_start           = 1'b1;
        i_cipher_key      = key;
        i_iv              = IV_A;
        i_aad_size        = aad;
        i_plain_text_size = pt;
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_cipher_key = '0;
        @(negedge clk);
        chk("start_new_inst", o_new_instance, 1'b1);
        chk("start_busy", o_busy, 1'b1);
        chk("start_key", o_cipher_key, key);
        chk("start_iv", o_iv, IV_A);
        chk("start_aad_size", o_aad_size, aad);
        chk("start_pt_size", o_plain_text_size, pt);
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit tog);
        bit got = 0;
        i_valid = 1'b1;
        i_data  = w;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (o_ready) got = 1;
            @(posedge clk); #1;
        end
        if (!got) chk("handshake_timeout", 1'b0, 1'b1);
        i_valid = 1'b0;
        i_data  = '0;
        if (tog) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic spurious();
        i_start      = 1'b1;
        i_cipher_key = KEY_B;
        i_blk_ack    = 1'b1;
        @(posedge clk); #1;
        i_start      = 1'b0;
        i_cipher_key = '0;
        i_blk_ack    = 1'b0;
        @(negedge clk);
        chk("spur_still_fill", o_ready, 1'b1);
        chk("spur_key_kept", o_cipher_key, KEY_A);
        @(posedge clk); #1;
    endtask

    task automatic feed_block(input int nw, input int base, input bit pt, input bit tog,
                              input logic [127:0] exp, input int spur);
        for (int k = 0; k < nw; k++) begin
            if (k == spur) spurious();
            send_word(wq[base+k], tog && (k != nw - 1));
        end
        @(negedge clk);
        chk("issue_rdy_c1", o_ready, 1'b0);
        if (pt) begin
            chk("pt_block", o_plain_text, exp);
            chk("pt_inst_c1", o_pt_instance, 1'b1);
        end else begin
            chk("aad_block", o_aad, exp);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("issue_rdy_c2", o_ready, 1'b0);
        if (pt) begin
            chk("pt_inst_c2", o_pt_instance, 1'b0);
            chk("pt_block_hold", o_plain_text, exp);
        end else begin
            chk("aad_block_hold", o_aad, exp);
        end
        @(posedge clk); #1;
        i_blk_ack = 1'b1;
        @(posedge clk); #1;
        i_blk_ack = 1'b0;
    endtask

    task automatic finish_tag();
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_busy", o_busy, 1'b1);
        chk("wait_no_done", o_done, 1'b0);
        chk("wait_no_ready", o_ready, 1'b0);
        @(posedge clk); #1;
        i_tag_ready = 1'b1;
        @(posedge clk); #1;
        i_tag_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", o_done, 1'b1);
        chk("done_idle", o_busy, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", o_done, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        int p0;
        int r0;
        rst_n = 1'b0; i_start = 1'b0; i_cipher_key = '0; i_iv = '0;
        i_aad_size = '0; i_plain_text_size = '0; i_data = '0; i_valid = 1'b0;
        i_blk_ack = 1'b0; i_tag_ready = 1'b0;

        // Reset state
        #23;
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_aad", o_aad, 128'h0);
        chk("rst_pt", o_plain_text, 128'h0);
        chk("rst_key", o_cipher_key, 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // aad=128, pt=256, words 1..12
        for (int i = 0; i < 12; i++) wq[i] = 32'(i + 1);
        n0 = new_cnt; p0 = pt_cnt;
        start_msg(64'd128, 64'd256, KEY_A);
        feed_block(4, 0, 1'b0, 1'b0, 128'h00000001_00000002_00000003_00000004, -1);
        feed_block(4, 4, 1'b1, 1'b0, 128'h00000005_00000006_00000007_00000008, -1);
        feed_block(4, 8, 1'b1, 1'b0, 128'h00000009_0000000A_0000000B_0000000C, -1);
        finish_tag();
        chk("m1_new_cnt", 32'(new_cnt - n0), 32'd1);
        chk("m1_pt_cnt", 32'(pt_cnt - p0), 32'd2);

        // aad=0, pt=96: words A,B,C go straight to plaintext, zero-padded
        wq[0] = 32'hAAAA0001; wq[1] = 32'hBBBB0002; wq[2] = 32'hCCCC0003;
        p0 = pt_cnt;
        start_msg(64'd0, 64'd96, KEY_A);
        feed_block(3, 0, 1'b1, 1'b0, 128'hAAAA0001_BBBB0002_CCCC0003_00000000, -1);
        chk("m2_aad_untouched", o_aad, 128'h00000001_00000002_00000003_00000004);
        finish_tag();
        chk("m2_pt_cnt", 32'(pt_cnt - p0), 32'd1);

        // aad=256, pt=32 with i_start and i_blk_ack injected mid-fill
        for (int i = 0; i < 8; i++) wq[i] = 32'h00000010 + 32'(i);
        wq[8] = 32'h00000099;
        n0 = new_cnt;
        start_msg(64'd256, 64'd32, KEY_A);
        feed_block(4, 0, 1'b0, 1'b0, 128'h00000010_00000011_00000012_00000013, 2);
        feed_block(4, 4, 1'b0, 1'b0, 128'h00000014_00000015_00000016_00000017, -1);
        feed_block(1, 8, 1'b1, 1'b0, 128'h00000099_00000000_00000000_00000000, -1);
        chk("m3_key_kept", o_cipher_key, KEY_A);
        chk("m3_aad_size_kept", o_aad_size, 64'd256);
        finish_tag();
        chk("m3_new_cnt", 32'(new_cnt - n0), 32'd1);

        // aad=128, pt=128 with i_valid toggling every cycle
        wq[0] = 32'h11111111; wq[1] = 32'h22222222; wq[2] = 32'h33333333; wq[3] = 32'h44444444;
        wq[4] = 32'h55555555; wq[5] = 32'h66666666; wq[6] = 32'h77777777; wq[7] = 32'h88888888;
        start_msg(64'd128, 64'd128, KEY_A);
        feed_block(4, 0, 1'b0, 1'b1, 128'h11111111_22222222_33333333_44444444, -1);
        feed_block(4, 4, 1'b1, 1'b1, 128'h55555555_66666666_77777777_88888888, -1);
        finish_tag();

        // aad=0, pt=0: straight to WAIT_TAG, no ready, no pt strobe
        p0 = pt_cnt; r0 = rdy_cnt; n0 = new_cnt;
        start_msg(64'd0, 64'd0, KEY_A);
        finish_tag();
        chk("m5_new_cnt", 32'(new_cnt - n0), 32'd1);
        chk("m5_no_pt", 32'(pt_cnt - p0), 32'd0);
        chk("m5_no_ready", 32'(rdy_cnt - r0), 32'd0);

        // Reset during FILL_PT, then a fresh message
        wq[0] = 32'h0000AB01; wq[1] = 32'h0000AB02;
        start_msg(64'd0, 64'd256, KEY_A);
        send_word(wq[0], 1'b0);
        send_word(wq[1], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", o_ready, 1'b0);
        chk("mrst_busy", o_busy, 1'b0);
        chk("mrst_key", o_cipher_key, 128'h0);
        chk("mrst_pt", o_plain_text, 128'h0);
        chk("mrst_pt_size", o_plain_text_size, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = new_cnt; p0 = pt_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", o_busy, 1'b0);
        end
        chk("post_rst_no_new", 32'(new_cnt - n0), 32'd0);
        chk("post_rst_no_pt", 32'(pt_cnt - p0), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) wq[i] = 32'h00000021 + 32'(i);
        start_msg(64'd0, 64'd128, KEY_B);
        feed_block(4, 0, 1'b1, 1'b0, 128'h00000021_00000022_00000023_00000024, -1);
        finish_tag();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcm_block_feeder.md
GCM_BLOCK_FEEDER -- requirements
Module: gcm_block_feeder

Interface
REQ-001 Parameter LEN_W, default 64: width of the bit-length inputs and outputs.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_start  in  1  one-cycle pulse that begins a message; sampled only in IDLE.
REQ-005 i_cipher_key  in  128  key, captured on accepted i_start.
REQ-006 i_iv  in  96  IV, captured on accepted i_start.
REQ-007 i_aad_size, i_plain_text_size  in  LEN_W each  lengths in bits, multiples of 32; captured on accepted i_start.
REQ-008 i_data  in  32  input word stream, AAD words first, then plaintext words.
REQ-009 i_valid / o_ready  in / out  1 each  word handshake; a word transfers when both are high on a clock edge.
REQ-010 o_new_instance, o_pt_instance  out  1 each  one-cycle strobes to the GCM core.
REQ-011 o_cipher_key 128, o_iv 96, o_aad 128, o_plain_text 128, o_aad_size LEN_W, o_plain_text_size LEN_W  out  registered operands for the GCM core; bit 0 is MSB.
REQ-012 i_blk_ack  in  1  core pulse: current block consumed.
REQ-013 i_tag_ready  in  1  core tag valid.
REQ-014 o_busy, o_done  out  1 each  o_busy is high outside IDLE; o_done is a one-cycle pulse on message completion.

Function
REQ-015 The FSM SHALL use states IDLE, INIT, FILL_AAD, ISSUE_AAD, FILL_PT, ISSUE_PT, WAIT_TAG.
REQ-016 IDLE with i_start: latch operands, go to INIT; i_start outside IDLE is ignored.
REQ-017 INIT: o_new_instance=1 for exactly one cycle; next state is FILL_AAD if aad_size≠0, else FILL_PT if pt_size≠0, else WAIT_TAG.
REQ-018 FILL_*: o_ready=1; word k of a block (k=0..3) is written to bits [32k:32k+31]; the fill ends after 4 words or the last word of the section.
REQ-019 A partial final block SHALL be zero-padded in the unfilled low-order words.
REQ-020 The block register SHALL be cleared to zero on entering each FILL_* state.
REQ-021 ISSUE_AAD: o_aad holds the block and o_ready=0 until i_blk_ack; then go to FILL_AAD if AAD words remain, else to FILL_PT/WAIT_TAG per REQ-017 rules.
REQ-022 ISSUE_PT: o_pt_instance=1 for the first cycle only; o_plain_text holds until i_blk_ack; then go to FILL_PT if words remain, else WAIT_TAG.
REQ-023 Remaining-word counters are LEN_W-5 bits, loaded with size>>5 and decremented per accepted word; no wrap below zero.
REQ-024 WAIT_TAG: on i_tag_ready, o_done=1 for one cycle, return to IDLE.
REQ-025 i_blk_ack outside ISSUE_* and i_tag_ready outside WAIT_TAG SHALL be ignored.
REQ-026 Input-to-block latency: a block is presented the cycle after its last word transfers.

Reset
REQ-027 While rst_n=0: state=IDLE, all outputs and registers zero (o_ready=0, o_busy=0, o_done=0).
REQ-028 Reset mid-message SHALL abandon the message without further strobes; the first cycle after release is IDLE.

Structure
REQ-029 State enum, GCM_BLK_W=128, WORD_W=32, and IV_W=96 SHALL live in shared package gcm_pkg.
REQ-030 The block SHALL be single-module; the 4-word packer is an optional sub-module gcm_word_packer.

Verification
REQ-031 aad=128, pt=256, words 0x00000001..0x0000000C, ack two cycles after each issue -> one o_new_instance; o_aad=0x00000001_00000002_00000003_00000004; two o_pt_instance strobes; o_done after i_tag_ready.
REQ-032 aad=0, pt=96, words A,B,C -> FILL_AAD is skipped; o_plain_text={A,B,C,0x00000000}.
REQ-033 aad=0, pt=0 -> o_new_instance, then WAIT_TAG, with no o_ready and no o_pt_instance.
REQ-034 i_valid toggled 1/0 every cycle during a 128-bit block -> same packed block; o_ready=0 throughout ISSUE_*.
REQ-035 rst_n pulsed low during FILL_PT -> all outputs zero immediately; a fresh i_start completes normally.
REQ-036 i_start and spurious i_blk_ack during FILL_AAD -> no state change; the message completes correctly.
